// File: rtl/cpu_result_checker_if.sv
// Snoop/result bundle between a CPU bench (master) and cpu_result_checker (slave).
// Carries the register-file write port, PC, per-check expectations and the verdict.
interface cpu_result_checker_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NCHECK = 4,
   parameter int unsigned CNTW   = 16
);
   logic                    start;
   logic [WIDTH-1:0]        pc;
   logic                    regWrEn;
   logic [4:0]              regWrAddr;
   logic [WIDTH-1:0]        regWrData;
   logic [NCHECK-1:0]       expEn;
   logic [5*NCHECK-1:0]     expAddr;
   logic [WIDTH*NCHECK-1:0] expData;
   logic                    busy;
   logic                    done;
   logic                    passed;
   logic                    timedOut;
   logic [NCHECK-1:0]       failMask;
   logic [CNTW-1:0]         cycles;

   modport master (
      output start, pc, regWrEn, regWrAddr, regWrData, expEn, expAddr, expData,
      input  busy, done, passed, timedOut, failMask, cycles
   );

   modport slave (
      input  start, pc, regWrEn, regWrAddr, regWrData, expEn, expAddr, expData,
      output busy, done, passed, timedOut, failMask, cycles
   );
endinterface

// File: rtl/cpu_result_checker.sv
// End-of-program checker: shadows selected register writes, detects jump-to-self
// halt or cycle timeout, then compares shadows against expected values.
module cpu_result_checker #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NCHECK      = 4,
   parameter int unsigned CNTW        = 16,
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned HALT_CYCLES = 3
) (
   input  logic               clk,
   input  logic               reset,
   cpu_result_checker_if.slave bus
);

   localparam int unsigned SCW = $clog2(HALT_CYCLES + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  shadow [NCHECK];
   logic [WIDTH-1:0]  prev_pc;
   logic [SCW-1:0]    same_count;
   logic              first_run;
   logic [CNTW-1:0]   cycles_q;
   logic              busy_q;
   logic              done_q;
   logic              passed_q;
   logic              timed_out_q;
   logic [NCHECK-1:0] fail_mask_q;

   logic [NCHECK-1:0] hit_c;
   logic [NCHECK-1:0] fail_c;
   logic [CNTW-1:0]   cycles_inc_c;
   logic              timeout_c;
   logic              halt_c;
   logic              pc_same_c;

   // Per-check write match (register 0 never captured) and mismatch against expectation
   always_comb begin
      hit_c  = '0;
      fail_c = '0;
      for (int i = 0; i < NCHECK; i++) begin
         hit_c[i]  = bus.regWrEn && (bus.regWrAddr != 5'd0) &&
                     (bus.expAddr[5*i +: 5] == bus.regWrAddr);
         fail_c[i] = bus.expEn[i] && (shadow[i] != bus.expData[WIDTH*i +: WIDTH]);
      end
   end

   always_comb begin
      cycles_inc_c = cycles_q + CNTW'(1);
      timeout_c    = (cycles_inc_c == CNTW'(TIMEOUT));
      halt_c       = (same_count == SCW'(HALT_CYCLES));
      pc_same_c    = (bus.pc == prev_pc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         prev_pc     <= '0;
         same_count  <= '0;
         first_run   <= 1'b0;
         cycles_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         passed_q    <= 1'b0;
         timed_out_q <= 1'b0;
         fail_mask_q <= '0;
         for (int i = 0; i < NCHECK; i++) shadow[i] <= '0;
      end else if (bus.start) begin
         // start restarts from any state and wipes the previous run
         state       <= ST_RUN;
         prev_pc     <= '0;
         same_count  <= '0;
         first_run   <= 1'b1;
         cycles_q    <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         passed_q    <= 1'b0;
         timed_out_q <= 1'b0;
         fail_mask_q <= '0;
         for (int i = 0; i < NCHECK; i++) shadow[i] <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               cycles_q  <= cycles_inc_c;
               prev_pc   <= bus.pc;
               first_run <= 1'b0;
               if (first_run || !pc_same_c) same_count <= '0;
               else                         same_count <= same_count + SCW'(1);
               for (int i = 0; i < NCHECK; i++) begin
                  if (hit_c[i]) shadow[i] <= bus.regWrData;
               end
               // Halt takes priority over a coincident timeout
               if (halt_c) begin
                  state <= ST_CHECK;
               end else if (timeout_c) begin
                  state       <= ST_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  passed_q    <= 1'b0;
                  timed_out_q <= 1'b1;
                  fail_mask_q <= '0;
               end
            end
            ST_CHECK: begin
               state       <= ST_DONE;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               fail_mask_q <= fail_c;
               passed_q    <= (fail_c == '0);
               timed_out_q <= 1'b0;
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.passed   = passed_q;
   assign bus.timedOut = timed_out_q;
   assign bus.failMask = fail_mask_q;
   assign bus.cycles   = cycles_q;

endmodule
